// File: rtl/right_shift_sequencer.sv
// Control stage for a single-step right shift register. It replays the register output back into it once per shift step.
// Optional build macro: SHIFT_SEQ_FASTZERO_EN (zero-amount requests bypass the register).
module right_shift_sequencer #(
    parameter  int WIDTH = 16,
    localparam int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_amt,
    input  logic             in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [WIDTH-1:0] sr_in,
    output logic             sr_enable,
    output logic             sr_mode,
    input  logic [WIDTH-1:0] sr_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [SHW-1:0] CNT_ZERO = SHW'(0);
    localparam logic [SHW-1:0] CNT_ONE  = SHW'(1);

    state_t           state_r;
    logic [WIDTH-1:0] op_r;
    logic [SHW-1:0]   cnt_r;
    logic             mode_r;
    logic             first_r;
`ifdef SHIFT_SEQ_FASTZERO_EN
    logic             zero_r;
`endif

    // Request capture and shift-step sequencing
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            op_r    <= {WIDTH{1'b0}};
            cnt_r   <= CNT_ZERO;
            mode_r  <= 1'b0;
            first_r <= 1'b0;
`ifdef SHIFT_SEQ_FASTZERO_EN
            zero_r  <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        op_r    <= in_data;
                        cnt_r   <= in_amt;
                        mode_r  <= in_mode;
                        first_r <= 1'b1;
`ifdef SHIFT_SEQ_FASTZERO_EN
                        zero_r  <= (in_amt == CNT_ZERO);
                        state_r <= (in_amt == CNT_ZERO) ? DONE : SHIFT;
`else
                        state_r <= SHIFT;
`endif
                    end
                end
                SHIFT: begin
                    first_r <= 1'b0;
                    // An amount of 0 or 1 needs exactly one register update
                    if (cnt_r <= CNT_ONE) begin
                        state_r <= DONE;
                    end else begin
                        cnt_r <= cnt_r - CNT_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // Register drive: feed the operand on the first step, then recirculate; hold otherwise
    always_comb begin
        sr_in     = sr_out;
        sr_enable = 1'b0;
        case (state_r)
            SHIFT: begin
                sr_in     = first_r ? op_r : sr_out;
                sr_enable = (cnt_r != CNT_ZERO);
            end
            IDLE, DONE: begin
                sr_in     = sr_out;
                sr_enable = 1'b0;
            end
            default: begin
                sr_in     = sr_out;
                sr_enable = 1'b0;
            end
        endcase
    end

    assign sr_mode   = mode_r;
    assign in_ready  = (state_r == IDLE);
    assign out_valid = (state_r == DONE);

    // Result select; the fast-zero path returns the captured operand untouched
    always_comb begin
        out_data = sr_out;
`ifdef SHIFT_SEQ_FASTZERO_EN
        if (zero_r) begin
            out_data = op_r;
        end else begin
            out_data = sr_out;
        end
`endif
    end

endmodule

// File: tb/tb_right_shift_sequencer.sv
// Bench for right_shift_sequencer with a behavioural single-step shift register attached.
module tb_right_shift_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in_data = 16'h0;
    logic [3:0]  in_amt = 4'h0;
    logic        in_mode = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] out_data;
    logic [15:0] sr_in;
    logic        sr_enable;
    logic        sr_mode;
    logic [15:0] sr_q = 16'h0;

    int n_checks = 0;
    int n_pass = 0;
    int n_fail = 0;

    right_shift_sequencer #(.WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_amt(in_amt), .in_mode(in_mode),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sr_in(sr_in), .sr_enable(sr_enable), .sr_mode(sr_mode), .sr_out(sr_q)
    );

    always #5 clk = ~clk;

    // The downstream single-step register: load, or load shifted right by one
    always @(posedge clk) begin
        if (!sr_enable)   sr_q <= sr_in;
        else if (sr_mode) sr_q <= {1'b0, sr_in[15:1]};
        else              sr_q <= {sr_in[15], sr_in[15:1]};
    end

    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt, input logic m);
        logic signed [15:0] s;
        s = d;
        if (m) return d >> amt;
        return s >>> amt;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic [15:0] d, input logic [3:0] a, input logic m, input int hold);
        logic [15:0] exp;
        int exp_shifts, shifts, ens, guard;
        exp = ref_shift(d, int'(a), m);
`ifdef SHIFT_SEQ_FASTZERO_EN
        exp_shifts = (a == 4'd0) ? 0 : int'(a);
`else
        exp_shifts = (a == 4'd0) ? 1 : int'(a);
`endif
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("ready_before", {31'b0, in_ready}, 32'd1);
        in_valid = 1'b1; in_data = d; in_amt = a; in_mode = m;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data = 16'($urandom); in_amt = 4'($urandom); in_mode = 1'($urandom);
        shifts = 0; ens = 0; guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 40) begin
            shifts++;
            if (sr_enable) ens++;
            in_valid = 1'($urandom);
            in_data = 16'($urandom);
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        check("shift_cycles", shifts, exp_shifts);
        check("enable_cycles", ens, int'(a));
        check("done_valid", {31'b0, out_valid}, 32'd1);
        check("done_data", {16'b0, out_data}, {16'b0, exp});
        check("done_ready", {31'b0, in_ready}, 32'd0);
        check("done_mode", {31'b0, sr_mode}, {31'b0, m});
        for (int i = 0; i < hold; i++) begin
            in_valid = (i % 2 == 0);
            in_data = 16'($urandom);
            in_amt = 4'($urandom);
            @(negedge clk);
            check("hold_data", {16'b0, out_data}, {16'b0, exp});
            check("hold_ready", {31'b0, in_ready}, 32'd0);
            check("hold_valid", {31'b0, out_valid}, 32'd1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("idle_ready", {31'b0, in_ready}, 32'd1);
        check("idle_valid", {31'b0, out_valid}, 32'd0);
        @(negedge clk);
        check("no_queue", {31'b0, in_ready}, 32'd1);
    endtask

    initial begin
        #2;
        check("rst_ready", {31'b0, in_ready}, 32'd1);
        check("rst_valid", {31'b0, out_valid}, 32'd0);
        check("rst_enable", {31'b0, sr_enable}, 32'd0);
        check("rst_mode", {31'b0, sr_mode}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        do_req(16'h8000, 4'd4, 1'b0, 5);
        do_req(16'h8000, 4'd4, 1'b1, 0);
        do_req(16'h8000, 4'd15, 1'b0, 1);
        do_req(16'h8000, 4'd15, 1'b1, 0);
        do_req(16'h1234, 4'd0, 1'b0, 2);
        do_req(16'h7FFF, 4'd1, 1'b0, 0);

        // Reset in the middle of an amount-8 request
        @(negedge clk);
        in_valid = 1'b1; in_data = 16'hABCD; in_amt = 4'd8; in_mode = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("mid_enable", {31'b0, sr_enable}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_valid", {31'b0, out_valid}, 32'd0);
        check("rst_mid_ready", {31'b0, in_ready}, 32'd1);
        check("rst_mid_enable", {31'b0, sr_enable}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {31'b0, in_ready}, 32'd1);
        do_req(16'h00F0, 4'd4, 1'b1, 0);

        for (int t = 0; t < 20; t++) begin
            do_req(16'($urandom), 4'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
